// File: rtl/tile_ctrl_param.sv
// tile_ctrl_param: sequences an MxN * NxT product over ARRxARR tiles (t inner, m middle, n outer),
// issuing row loads, a fixed RUN window and accumulate-or-store handshakes per tile.
module tile_ctrl_param #(
  parameter int ARR = 4,
  parameter int DIMW = 5,
  parameter int DATA_W = 8,
  localparam int CW = $clog2(ARR),
  localparam int TIW = DIMW - CW,
  localparam int AW = 2 * TIW + CW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [3*DIMW-1:0] MNT,
  input  logic              Tile_Done,
  input  logic              LOAD_DONE,
  input  logic              STORE_DONE,
  input  logic              INIT_DONE,
  output logic              LOAD_I,
  output logic              LOAD_W,
  output logic              START_CALC,
  output logic              ACC,
  output logic              OMSRC,
  output logic [CW-1:0]     ICOL,
  output logic [CW-1:0]     WROW,
  output logic [CW:0]       ROW_TOTAL,
  output logic [AW-1:0]     ADDR_I,
  output logic [AW-1:0]     ADDR_W,
  output logic [AW-1:0]     ODST,
  output logic [15:0]       SHAMT,
  output logic              CLR_DP,
  output logic              CLR_W,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);
  typedef enum logic [2:0] {IDLE, LOAD_BOTH, LOAD_INPUT, RUN, WAIT, STORE_ACC, BRANCH, FIN} state_t;
  state_t state_q, state_d;
  logic [DIMW-1:0] m_dim_q, m_dim_d, n_dim_q, n_dim_d, t_dim_q, t_dim_d;
  logic [TIW-1:0] t_q, t_d, m_q, m_d, n_q, n_d;
  logic [CW:0] icnt_q, icnt_d, wcnt_q, wcnt_d;
  logic [CW-1:0] run_q, run_d;
  logic done_q, done_d, err_q, err_d, omsrc_q, omsrc_d;
  logic load_i, load_w, clr_dp, clr_w, adv;
  logic [CW:0] rem_t, rem_m, rem_n;
  logic [DIMW:0] tot_t, tot_m, tot_n;

  function automatic logic [DIMW:0] tiles(input logic [DIMW-1:0] x);
    return ((DIMW+1)'(x) + (DIMW+1)'(ARR - 1)) >> CW;
  endfunction

  // Remaining rows of the current tile, clamped to the array edge.
  function automatic logic [CW:0] rem(input logic [DIMW-1:0] x, input logic [TIW-1:0] i);
    logic [DIMW:0] r;
    r = (DIMW+1)'(x) - ((DIMW+1)'(i) << CW);
    return r > (DIMW+1)'(ARR) ? (CW+1)'(ARR) : r[CW:0];
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      m_dim_q <= '0;
      n_dim_q <= '0;
      t_dim_q <= '0;
      t_q <= '0;
      m_q <= '0;
      n_q <= '0;
      icnt_q <= '0;
      wcnt_q <= '0;
      run_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      omsrc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_dim_q <= m_dim_d;
      n_dim_q <= n_dim_d;
      t_dim_q <= t_dim_d;
      t_q <= t_d;
      m_q <= m_d;
      n_q <= n_d;
      icnt_q <= icnt_d;
      wcnt_q <= wcnt_d;
      run_q <= run_d;
      done_q <= done_d;
      err_q <= err_d;
      omsrc_q <= omsrc_d;
    end
  end

  always_comb begin
    tot_t = tiles(t_dim_q);
    tot_m = tiles(m_dim_q);
    tot_n = tiles(n_dim_q);
    rem_t = rem(t_dim_q, t_q);
    rem_m = rem(m_dim_q, m_q);
    rem_n = rem(n_dim_q, n_q);
    state_d = state_q;
    m_dim_d = m_dim_q;
    n_dim_d = n_dim_q;
    t_dim_d = t_dim_q;
    t_d = t_q;
    m_d = m_q;
    n_d = n_q;
    icnt_d = '0;
    wcnt_d = '0;
    run_d = '0;
    done_d = 1'b0;
    err_d = err_q;
    load_i = 1'b0;
    load_w = 1'b0;
    clr_dp = 1'b0;
    clr_w = 1'b0;
    adv = 1'b0;
    omsrc_d = ~INIT_DONE | (state_q == STORE_ACC);
    case (state_q)
      IDLE: if (Start) begin
        if (~|MNT[3*DIMW-1:2*DIMW] | ~|MNT[2*DIMW-1:DIMW] | ~|MNT[DIMW-1:0]) begin
          done_d = 1'b1;
          err_d = 1'b1;
        end else begin
          {m_dim_d, n_dim_d, t_dim_d} = MNT;
          err_d = 1'b0;
          state_d = LOAD_BOTH;
        end
      end
      LOAD_BOTH, LOAD_INPUT: begin
        load_i = icnt_q < rem_t;
        load_w = (state_q == LOAD_BOTH) && (wcnt_q < rem_m);
        icnt_d = icnt_q + (CW+1)'(load_i);
        wcnt_d = wcnt_q + (CW+1)'(load_w);
        state_d = (!load_i && !load_w) ? RUN : state_q;
      end
      RUN: begin
        run_d = run_q + 1'b1;
        state_d = (run_q == CW'(ARR - 1)) ? WAIT : RUN;
      end
      WAIT: begin
        adv = (n_q == '0) && Tile_Done;
        state_d = (n_q != '0) ? (LOAD_DONE ? STORE_ACC : WAIT) : (Tile_Done ? BRANCH : WAIT);
      end
      STORE_ACC: begin
        adv = STORE_DONE;
        state_d = STORE_DONE ? BRANCH : STORE_ACC;
      end
      // Pointers have already advanced here; wrapping to all-zero means the job is finished.
      BRANCH: begin
        clr_dp = 1'b1;
        clr_w = (t_q == '0);
        done_d = (t_q == '0) && (m_q == '0) && (n_q == '0);
        state_d = done_d ? FIN : (t_q != '0) ? LOAD_INPUT : LOAD_BOTH;
      end
      FIN: begin
        t_d = '0;
        m_d = '0;
        n_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      t_d = (t_q == TIW'(tot_t - 1'b1)) ? '0 : t_q + 1'b1;
      if (t_q == TIW'(tot_t - 1'b1)) begin
        m_d = (m_q == TIW'(tot_m - 1'b1)) ? '0 : m_q + 1'b1;
        if (m_q == TIW'(tot_m - 1'b1)) n_d = (n_q == TIW'(tot_n - 1'b1)) ? '0 : n_q + 1'b1;
      end
    end
  end

  assign LOAD_I = load_i;
  assign LOAD_W = load_w;
  assign START_CALC = state_q == RUN;
  assign ACC = n_q != '0;
  assign OMSRC = omsrc_q;
  assign ICOL = icnt_q[CW-1:0];
  assign WROW = wcnt_q[CW-1:0];
  assign ROW_TOTAL = rem_t;
  assign ADDR_I = {n_q, t_q, icnt_q[CW-1:0]};
  assign ADDR_W = {n_q, m_q, wcnt_q[CW-1:0]};
  assign ODST = {m_q, t_q, icnt_q[CW-1:0]};
  assign SHAMT = 16'((ARR - int'(rem_n)) * DATA_W);
  assign CLR_DP = clr_dp;
  assign CLR_W = clr_w;
  assign BUSY = state_q != IDLE;
  assign DONE = done_q;
  assign ERR = err_q;
endmodule

// File: tb/tb_tile_ctrl_param.sv
// tb_tile_ctrl_param: drives whole jobs against a tile-list model of the sequencer and checks
// loads, addresses, run window, accumulate handshakes, clears, DONE/ERR and reset abort.
module tb_tile_ctrl_param;
  localparam int ARR = 4;
  localparam int DIMW = 5;
  localparam int DATA_W = 8;
  localparam int CW = 2;
  localparam int TIW = 3;
  localparam int AW = 8;
  logic CLK = 1'b0;
  logic RST, Start, Tile_Done, LOAD_DONE, STORE_DONE, INIT_DONE;
  logic [3*DIMW-1:0] MNT;
  logic LOAD_I, LOAD_W, START_CALC, ACC, OMSRC, CLR_DP, CLR_W, BUSY, DONE, ERR;
  logic [CW-1:0] ICOL, WROW;
  logic [CW:0] ROW_TOTAL;
  logic [AW-1:0] ADDR_I, ADDR_W, ODST;
  logic [15:0] SHAMT;
  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  tile_ctrl_param #(.ARR(ARR), .DIMW(DIMW), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .MNT(MNT), .Tile_Done(Tile_Done),
    .LOAD_DONE(LOAD_DONE), .STORE_DONE(STORE_DONE), .INIT_DONE(INIT_DONE),
    .LOAD_I(LOAD_I), .LOAD_W(LOAD_W), .START_CALC(START_CALC), .ACC(ACC), .OMSRC(OMSRC),
    .ICOL(ICOL), .WROW(WROW), .ROW_TOTAL(ROW_TOTAL), .ADDR_I(ADDR_I), .ADDR_W(ADDR_W),
    .ODST(ODST), .SHAMT(SHAMT), .CLR_DP(CLR_DP), .CLR_W(CLR_W), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  function automatic int rem(input int x, input int i);
    return (x - ARR * i) < ARR ? x - ARR * i : ARR;
  endfunction

  task automatic run_job(input int mm, input int nn, input int tdim, input int abort_tile);
    int tn, tm, tt, tile, ic, wc, rc, rt, rm, rn, nt, k, d;
    bit last;
    tn = (nn + ARR - 1) / ARR;
    tm = (mm + ARR - 1) / ARR;
    tt = (tdim + ARR - 1) / ARR;
    tile = 0;
    @(negedge CLK);
    Start = 1'b1;
    MNT = {DIMW'(mm), DIMW'(nn), DIMW'(tdim)};
    for (int n = 0; n < tn; n++)
      for (int m = 0; m < tm; m++)
        for (int t = 0; t < tt; t++) begin
          rt = rem(tdim, t);
          rm = rem(mm, m);
          rn = rem(nn, n);
          ic = 0;
          wc = 0;
          for (k = 0; k < 40; k++) begin
            @(negedge CLK);
            Start = 1'(($urandom % 2));
            if (tile == 0 && k == 0) begin
              vectors++;
              if ({ERR, BUSY} !== 2'b01) begin miscompares++; $display("FAIL job_start ERR,BUSY got %b want 01", {ERR, BUSY}); end
            end
            if (START_CALC) break;
            if (LOAD_I) begin
              vectors++;
              if (ADDR_I !== AW'(n * 32 + t * 4 + ic) || ODST !== AW'(m * 32 + t * 4 + ic) || ICOL !== CW'(ic & 3)) begin
                miscompares++;
                $display("FAIL addr_i tile %0d row %0d got ADDR_I=%0d ODST=%0d ICOL=%0d want %0d %0d %0d",
                         tile, ic, ADDR_I, ODST, ICOL, n * 32 + t * 4 + ic, m * 32 + t * 4 + ic, ic & 3);
              end
              ic++;
            end
            if (LOAD_W) begin
              vectors++;
              if (ADDR_W !== AW'(n * 32 + m * 4 + wc) || WROW !== CW'(wc & 3)) begin
                miscompares++;
                $display("FAIL addr_w tile %0d row %0d got %0d/%0d want %0d/%0d", tile, wc, ADDR_W, WROW, n * 32 + m * 4 + wc, wc & 3);
              end
              wc++;
            end
          end
          Start = 1'b0;
          if (k == 40) begin
            miscompares++;
            $display("FAIL run_timeout tile %0d got no START_CALC want START_CALC within 40 cycles", tile);
            return;
          end
          if (tile == abort_tile) begin
            RST = 1'b1;
            #1;
            vectors++;
            if ({BUSY, START_CALC, LOAD_I, LOAD_W, DONE, ERR, ACC, OMSRC, CLR_DP, CLR_W, ROW_TOTAL, ADDR_I} !== '0) begin
              miscompares++;
              $display("FAIL abort_outputs got BUSY=%b RUN=%b DONE=%b ACC=%b ROW_TOTAL=%0d ADDR_I=%0d want all 0",
                       BUSY, START_CALC, DONE, ACC, ROW_TOTAL, ADDR_I);
            end
            @(negedge CLK);
            RST = 1'b0;
            @(negedge CLK);
            vectors++;
            if ({BUSY, DONE} !== 2'b00) begin miscompares++; $display("FAIL abort_idle BUSY,DONE got %b want 00", {BUSY, DONE}); end
            return;
          end
          vectors++;
          if (ic !== rt || wc !== (t == 0 ? rm : 0)) begin
            miscompares++;
            $display("FAIL load_count tile %0d got I=%0d W=%0d want I=%0d W=%0d", tile, ic, wc, rt, t == 0 ? rm : 0);
          end
          rc = 1;
          for (k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (!START_CALC) break;
            rc++;
          end
          vectors++;
          if (rc !== ARR) begin miscompares++; $display("FAIL run_len tile %0d got %0d want %0d", tile, rc, ARR); end
          vectors++;
          if (ACC !== (n != 0) || ROW_TOTAL !== (CW+1)'(rt) || SHAMT !== 16'((ARR - rn) * DATA_W) || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_outputs tile %0d got ACC=%b ROW_TOTAL=%0d SHAMT=%0d BUSY=%b want %b %0d %0d 1",
                     tile, ACC, ROW_TOTAL, SHAMT, BUSY, n != 0, rt, (ARR - rn) * DATA_W);
          end
          repeat ($urandom % 3) @(negedge CLK);
          Tile_Done = 1'b1;
          LOAD_DONE = 1'b1;
          @(negedge CLK);
          Tile_Done = 1'b0;
          LOAD_DONE = 1'b0;
          if (n != 0) begin
            d = 1 + $urandom % 3;
            for (int j = 1; j <= d; j++) begin
              if (j > 1) @(negedge CLK);
              vectors++;
              if (OMSRC !== (j >= 2) || CLR_DP !== 1'b0) begin
                miscompares++;
                $display("FAIL store_wait tile %0d cycle %0d got OMSRC=%b CLR_DP=%b want %b 0", tile, j, OMSRC, CLR_DP, j >= 2);
              end
            end
            STORE_DONE = 1'b1;
            @(negedge CLK);
            STORE_DONE = 1'b0;
          end
          last = (n == tn - 1) && (m == tm - 1) && (t == tt - 1);
          nt = (t + 1 == tt) ? 0 : t + 1;
          vectors++;
          if (CLR_DP !== 1'b1 || CLR_W !== (last || nt == 0) || DONE !== 1'b0 || OMSRC !== (n != 0)) begin
            miscompares++;
            $display("FAIL branch tile %0d got CLR_DP=%b CLR_W=%b DONE=%b OMSRC=%b want 1 %b 0 %b",
                     tile, CLR_DP, CLR_W, DONE, OMSRC, last || nt == 0, n != 0);
          end
          tile++;
        end
    @(negedge CLK);
    vectors++;
    if ({DONE, BUSY} !== 2'b11) begin miscompares++; $display("FAIL fin DONE,BUSY got %b want 11", {DONE, BUSY}); end
    @(negedge CLK);
    vectors++;
    if ({DONE, BUSY, ACC} !== 3'b000) begin miscompares++; $display("FAIL idle_after DONE,BUSY,ACC got %b want 000", {DONE, BUSY, ACC}); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    vectors++;
    if ({BUSY, DONE, ERR, LOAD_I, LOAD_W, START_CALC, ACC, OMSRC, CLR_DP, CLR_W, ROW_TOTAL, ADDR_I, ADDR_W, ODST} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got BUSY=%b DONE=%b ERR=%b OMSRC=%b ROW_TOTAL=%0d want all 0", BUSY, DONE, ERR, OMSRC, ROW_TOTAL);
    end
    @(negedge CLK);
    RST = 1'b0;
    INIT_DONE = 1'b0;
    @(negedge CLK);
    vectors++;
    if (OMSRC !== 1'b1) begin miscompares++; $display("FAIL omsrc_init got %b want 1", OMSRC); end
    INIT_DONE = 1'b1;
    @(negedge CLK);
    vectors++;
    if (OMSRC !== 1'b0) begin miscompares++; $display("FAIL omsrc_ready got %b want 0", OMSRC); end
  endtask

  task automatic test_zero_dim();
    logic [3*DIMW-1:0] bad [3];
    bad[0] = {5'd0, 5'd4, 5'd4};
    bad[1] = {5'd4, 5'd0, 5'd4};
    bad[2] = {5'd4, 5'd4, 5'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      Start = 1'b1;
      MNT = bad[i];
      @(negedge CLK);
      Start = 1'b0;
      vectors++;
      if ({DONE, ERR, BUSY, LOAD_I, LOAD_W} !== 5'b11000) begin
        miscompares++;
        $display("FAIL reject %0d DONE,ERR,BUSY,LOAD_I,LOAD_W got %b want 11000", i, {DONE, ERR, BUSY, LOAD_I, LOAD_W});
      end
      @(negedge CLK);
      vectors++;
      if ({DONE, ERR, BUSY} !== 3'b010) begin miscompares++; $display("FAIL reject_after %0d got %b want 010", i, {DONE, ERR, BUSY}); end
    end
  endtask

  task automatic test_random_jobs();
    for (int i = 0; i < 6; i++) run_job(1 + $urandom % 14, 1 + $urandom % 14, 1 + $urandom % 14, -1);
  endtask

  initial begin
    RST = 1'b1;
    Start = 1'b0;
    MNT = '0;
    Tile_Done = 1'b0;
    LOAD_DONE = 1'b0;
    STORE_DONE = 1'b0;
    INIT_DONE = 1'b1;
    test_reset();
    run_job(4, 4, 4, -1);
    run_job(8, 8, 5, -1);
    run_job(3, 6, 3, -1);
    test_zero_dim();
    run_job(1, 1, 1, -1);
    run_job(8, 8, 8, 3);
    run_job(8, 8, 8, -1);
    run_job(31, 5, 31, -1);
    test_random_jobs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
